mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle main controller that sequences the team's shared-memory MIPS datapath: one memory port serves instruction fetch and load/store.
- Moore FSM decodes Opcode/Funct and drives the datapath mux selects and write enables.
- Stalls on a memory ready handshake and emits a retire pulse per completed instruction.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles to wait for mem_ready before flagging bus_err; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
Opcode  in  6  Instr[31:26] from instruction register
Funct  in  6  Instr[5:0]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_en  out  1  PC register load enable
IorD  out  1  0 = address is PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
RegDst  out  1  0 = rt, 1 = rd
MemtoReg  out  1  0 = ALUOut, 1 = memory data register
RegWrite  out  1  register file write enable
JAL  out  1  force write register to 31 and write data to PC
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left 2
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A
ALUControl  out  4  ALU operation code
retire  out  1  one-cycle pulse when an instruction completes
illegal  out  1  one-cycle pulse on an unsupported opcode or funct
bus_err  out  1  sticky; set on timeout, cleared only by reset
state  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. While reset is high, state becomes FETCH and counters clear.
- Reset outputs: while reset is high, pc_en, MemRead, MemWrite, IRWrite, RegWrite, retire and illegal are forced to 0 and bus_err clears. The first cycle after reset deasserts is FETCH.
- Output timing: all outputs decode combinationally from the state register. pc_en = PCWrite | (Branch & Zero) | (BranchNe & ~Zero).
- ALU codes: ADD=0010, SUB=0110, AND=0000, OR=0001, SLT=0111, NOR=1100, SLL=1000, SRL=1001.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSource=00.
  - IRWrite and PCWrite assert only in the cycle mem_ready=1; the FSM then goes to DECODE. Otherwise it holds in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD (precomputes the branch target into ALUOut). Next state by Opcode:
  - 000000 → RTYPE, except Funct 001000 → JR
  - 100011 or 101011 → MEMADR
  - 000100 → BEQ; 000101 → BNE
  - 001000 → ADDI; 001010 → SLTI
  - 000010 → JUMP; 000011 → JALS
  - any other opcode → FETCH with illegal pulsed; no register or memory write occurs.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Goes to MEMRD for 100011, MEMWR for 101011.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, retire. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready; retire pulses in the mem_ready cycle; then goes to FETCH.
- RTYPE: ALUSrcA=1, ALUSrcB=00, Funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL.
  - Supported funct → ALUWB. Other funct → FETCH with illegal pulsed.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, retire. Goes to FETCH.
- ADDI / SLTI: ALUSrcA=1, ALUSrcB=10, ADD or SLT respectively. Goes to IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0, retire. Goes to FETCH.
- BEQ / BNE: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01. Branch (BEQ) or BranchNe (BNE) asserted; retire. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10, retire. Goes to FETCH.
- JALS: PCWrite=1, PCSource=10, RegWrite=1, JAL=1, retire. The PC already holds PC+4, so that is the value written to register 31. Goes to FETCH.
- JR: PCWrite=1, PCSource=11, retire. Goes to FETCH.
- Timeout: a wait counter runs in FETCH, MEMRD and MEMWR and clears on any state change.
  - When the count reaches MEM_TIMEOUT with mem_ready still low: bus_err sets, and the FSM parks in HALT.
  - HALT drives all enables to 0 and is exited only by reset.
  - mem_ready arriving in the same cycle as the timeout wins.
- Reset mid-access abandons the access; no write enable is asserted in the reset cycle.
- CPI: 3 for jumps and branches, 4 for ALU ops and sw, 5 for lw; each memory state adds one cycle per stall cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE, ALUWB, ADDI, SLTI, IWB, BEQ, BNE, JUMP, JALS, JR, HALT — 17 states, so a 5-bit internal encoding)
  - opcode and funct constants
  - ALUControl constants
  - ALUSrcB and PCSource select encodings
- The debug state port is 4 bits wide, so HALT is reported as 4'hF.
- One sub-module, mc_alu_decoder: a combinational map from (ALU-op class, Funct) to ALUControl plus a funct_valid flag.

Test Plan:
- Reset held 2 cycles, then mem_ready=1 constantly → cycle 1 shows FETCH with MemRead=1, IRWrite=1, pc_en=1; all enables are 0 during reset.
- lw (Opcode 100011), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 with MemtoReg=1 in cycle 5; one retire pulse.
- Fetch with mem_ready low for 3 cycles → FETCH held 4 cycles; IRWrite and pc_en stay 0 until the mem_ready cycle.
- beq with Zero=1 → pc_en=1, PCSource=01 in cycle 3; with Zero=0 → pc_en=0. bne gives the inverse.
- jal (000011) → cycle 3 has RegWrite=1, JAL=1, PCSource=10, pc_en=1. jr (Funct 001000) → PCSource=11.
- Opcode 111111 → illegal pulses and the next state is FETCH. With MEM_TIMEOUT=4 and mem_ready low in MEMRD → bus_err=1, state=4'hF, enables stay 0 until reset.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller: state encoding,
// instruction field constants, ALU operation codes and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,
        S_DECODE = 5'd1,
        S_MEMADR = 5'd2,
        S_MEMRD  = 5'd3,
        S_MEMWB  = 5'd4,
        S_MEMWR  = 5'd5,
        S_RTYPE  = 5'd6,
        S_ALUWB  = 5'd7,
        S_ADDI   = 5'd8,
        S_SLTI   = 5'd9,
        S_IWB    = 5'd10,
        S_BEQ    = 5'd11,
        S_BNE    = 5'd12,
        S_JUMP   = 5'd13,
        S_JALS   = 5'd14,
        S_JR     = 5'd15,
        S_HALT   = 5'd16
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_SLT,
        ALUOP_FUNCT
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // The debug port is only 4 bits, so HALT folds onto 4'hF.
    function automatic logic [3:0] state_debug(input state_t s);
        logic [4:0] v;
        v = s;
        return (s == S_HALT) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the controller's ALU-op class and the R-type Funct field onto an ALUControl
// code; funct_valid drops for R-type functs the datapath cannot execute.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_control,
    output logic       o_funct_valid
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_funct_valid = 1'b1;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_SLT: o_alu_control = ALU_SLT;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_NOR:  o_alu_control = ALU_NOR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    FN_SLL:  o_alu_control = ALU_SLL;
                    FN_SRL:  o_alu_control = ALU_SRL;
                    default: o_funct_valid = 1'b0;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore main controller for the shared-memory multi-cycle MIPS datapath: sequences
// fetch/decode/execute, stalls on mem_ready and parks in HALT on a memory timeout.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       JAL,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUControl,
    output logic       retire,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_bus_err;

    logic       w_waiting, w_timeout, w_op_valid, w_funct_valid;
    alu_op_t    w_alu_op;
    logic [3:0] w_alu_control;
    logic       w_pc_write, w_branch, w_branch_ne, w_iord, w_mem_read, w_mem_write;
    logic       w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write, w_jal, w_alu_src_a;
    logic [1:0] w_alu_src_b, w_pc_source;
    logic       w_retire, w_illegal;

    assign w_waiting  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // A ready arriving in the limit cycle completes the access instead of faulting.
    assign w_timeout  = (MEM_TIMEOUT != 0) && w_waiting && !mem_ready && (r_wait_cnt == CNT_LIMIT);
    assign w_op_valid = Opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                                       OP_ADDI, OP_SLTI, OP_J, OP_JAL};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_timeout)
                r_bus_err <= 1'b1;
            if ((w_state_next != r_state) || !w_waiting || (MEM_TIMEOUT == 0))
                r_wait_cnt <= '0;
            else
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_HALT;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     w_state_next = (Funct == FN_JR) ? S_JR : S_RTYPE;
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_BEQ:       w_state_next = S_BEQ;
                    OP_BNE:       w_state_next = S_BNE;
                    OP_ADDI:      w_state_next = S_ADDI;
                    OP_SLTI:      w_state_next = S_SLTI;
                    OP_J:         w_state_next = S_JUMP;
                    OP_JAL:       w_state_next = S_JALS;
                    default:      w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_state_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)      w_state_next = S_MEMWB;
                else if (w_timeout) w_state_next = S_HALT;
            end
            S_MEMWR: begin
                if (mem_ready)      w_state_next = S_FETCH;
                else if (w_timeout) w_state_next = S_HALT;
            end
            S_RTYPE:        w_state_next = w_funct_valid ? S_ALUWB : S_FETCH;
            S_ADDI, S_SLTI: w_state_next = S_IWB;
            S_HALT:         w_state_next = S_HALT;
            default:        w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (r_state)
            S_RTYPE:      w_alu_op = ALUOP_FUNCT;
            S_BEQ, S_BNE: w_alu_op = ALUOP_SUB;
            S_SLTI:       w_alu_op = ALUOP_SLT;
            default:      w_alu_op = ALUOP_ADD;
        endcase
    end

    mc_alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct       (Funct),
        .o_alu_control (w_alu_control),
        .o_funct_valid (w_funct_valid)
    );

    always_comb begin
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_jal        = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = SRCB_REG;
        w_pc_source  = PCSRC_ALU;
        w_retire     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
            end
            S_DECODE: begin
                w_alu_src_b = SRCB_IMM_SH;
                w_illegal   = !w_op_valid;
            end
            S_MEMADR, S_ADDI, S_SLTI: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                w_retire    = mem_ready;
            end
            S_RTYPE: begin
                w_alu_src_a = 1'b1;
                w_illegal   = !w_funct_valid;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
            end
            S_IWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BEQ, S_BNE: begin
                w_alu_src_a = 1'b1;
                w_pc_source = PCSRC_ALUOUT;
                w_branch    = (r_state == S_BEQ);
                w_branch_ne = (r_state == S_BNE);
                w_retire    = 1'b1;
            end
            S_JUMP, S_JALS: begin
                w_pc_write  = 1'b1;
                w_pc_source = PCSRC_JUMP;
                w_reg_write = (r_state == S_JALS);
                w_jal       = (r_state == S_JALS);
                w_retire    = 1'b1;
            end
            S_JR: begin
                w_pc_write  = 1'b1;
                w_pc_source = PCSRC_REG;
                w_retire    = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked during reset so an abandoned access cannot commit.
    assign pc_en      = ~reset & (w_pc_write | (w_branch & Zero) | (w_branch_ne & ~Zero));
    assign MemRead    = ~reset & w_mem_read;
    assign MemWrite   = ~reset & w_mem_write;
    assign IRWrite    = ~reset & w_ir_write;
    assign RegWrite   = ~reset & w_reg_write;
    assign JAL        = ~reset & w_jal;
    assign retire     = ~reset & w_retire;
    assign illegal    = ~reset & w_illegal;
    assign bus_err    = ~reset & r_bus_err;
    assign IorD       = w_iord;
    assign RegDst     = w_reg_dst;
    assign MemtoReg   = w_mem_to_reg;
    assign ALUSrcA    = w_alu_src_a;
    assign ALUSrcB    = w_alu_src_b;
    assign PCSource   = w_pc_source;
    assign ALUControl = w_alu_control;
    assign state      = state_debug(r_state);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: stimulus queues the expected control word for
// each cycle, and a negedge monitor pops and compares against the live outputs.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       pc_en;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegDst;
        logic       MemtoReg;
        logic       RegWrite;
        logic       JAL;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] PCSource;
        logic [3:0] ALUControl;
        logic       retire;
        logic       illegal;
        logic       bus_err;
        logic [3:0] state;
    } ctl_t;

    typedef struct {
        string nm;
        ctl_t  e;
        ctl_t  c;
    } exp_t;

    logic       clk, reset, Zero, mem_ready;
    logic [5:0] Opcode, Funct;
    logic       pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, JAL, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUControl, state;
    logic       retire, illegal, bus_err;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    mc_control_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .JAL(JAL), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUControl(ALUControl), .retire(retire), .illegal(illegal),
        .bus_err(bus_err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Monitor: one comparison per queued cycle expectation.
    initial begin
        exp_t x;
        ctl_t act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                act.pc_en = pc_en;       act.IorD = IorD;         act.MemRead = MemRead;
                act.MemWrite = MemWrite; act.IRWrite = IRWrite;   act.RegDst = RegDst;
                act.MemtoReg = MemtoReg; act.RegWrite = RegWrite; act.JAL = JAL;
                act.ALUSrcA = ALUSrcA;   act.ALUSrcB = ALUSrcB;   act.PCSource = PCSource;
                act.ALUControl = ALUControl; act.retire = retire; act.illegal = illegal;
                act.bus_err = bus_err;   act.state = state;
                n_chk++;
                if (((act ^ x.e) & x.c) !== '0) begin
                    n_err++;
                    $display("FAIL %s: got %07h want %07h (care %07h)", x.nm, act, x.e, x.c);
                end else begin
                    $display("chk %0d %s state=%h ok", n_chk, x.nm, state);
                end
            end
        end
    end

    function automatic ctl_t cen();
        ctl_t c = '0;
        c.pc_en = 1'b1; c.MemRead = 1'b1; c.MemWrite = 1'b1; c.IRWrite = 1'b1;
        c.RegWrite = 1'b1; c.JAL = 1'b1; c.retire = 1'b1; c.illegal = 1'b1;
        c.bus_err = 1'b1; c.state = 4'hF;
        return c;
    endfunction

    task automatic go(input string nm, input ctl_t e, input ctl_t c);
        exp_t x;
        x.nm = nm; x.e = e; x.c = c;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        Opcode = op;
        Funct  = fn;
    endtask

    task automatic t_reset(input bit chk_state);
        ctl_t e = '0;
        ctl_t c = cen();
        reset = 1'b1;
        mem_ready = 1'b1;
        if (!chk_state) c.state = 4'h0;
        go("reset", e, c);
        reset = 1'b0;
    endtask

    task automatic t_fetch(input logic rdy);
        ctl_t e = '0;
        ctl_t c = cen();
        mem_ready = rdy;
        e.state = 4'd0; e.MemRead = 1'b1; e.IRWrite = rdy; e.pc_en = rdy;
        e.ALUSrcB = 2'b01; e.ALUControl = 4'b0010;
        c.IorD = 1'b1; c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b11; c.PCSource = 2'b11; c.ALUControl = 4'hF;
        go(rdy ? "fetch" : "fetch_stall", e, c);
    endtask

    task automatic t_decode(input logic ill);
        ctl_t e = '0;
        ctl_t c = cen();
        mem_ready = 1'b1;
        e.state = 4'd1; e.ALUSrcB = 2'b11; e.ALUControl = 4'b0010; e.illegal = ill;
        c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b11; c.ALUControl = 4'hF;
        go(ill ? "decode_illegal" : "decode", e, c);
    endtask

    task automatic t_exec_imm(input string nm, input logic [3:0] st, input logic [3:0] aluc);
        ctl_t e = '0;
        ctl_t c = cen();
        e.state = st; e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; e.ALUControl = aluc;
        c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b11; c.ALUControl = 4'hF;
        go(nm, e, c);
    endtask

    task automatic t_mem(input logic wr, input logic rdy);
        ctl_t e = '0;
        ctl_t c = cen();
        mem_ready = rdy;
        e.state = wr ? 4'd5 : 4'd3; e.IorD = 1'b1;
        e.MemRead = !wr; e.MemWrite = wr; e.retire = wr & rdy;
        c.IorD = 1'b1;
        go(wr ? "memwr" : "memrd", e, c);
    endtask

    task automatic t_wb(input string nm, input logic [3:0] st, input logic rd, input logic m2r);
        ctl_t e = '0;
        ctl_t c = cen();
        mem_ready = 1'b1;
        e.state = st; e.RegWrite = 1'b1; e.RegDst = rd; e.MemtoReg = m2r; e.retire = 1'b1;
        c.RegDst = 1'b1; c.MemtoReg = 1'b1;
        go(nm, e, c);
    endtask

    task automatic t_rtype(input logic [3:0] aluc, input logic ill);
        ctl_t e = '0;
        ctl_t c = cen();
        e.state = 4'd6; e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b00; e.ALUControl = aluc; e.illegal = ill;
        c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b11;
        if (!ill) c.ALUControl = 4'hF;
        go(ill ? "rtype_illegal" : "rtype", e, c);
    endtask

    task automatic t_br(input string nm, input logic [3:0] st, input logic z, input logic pcen);
        ctl_t e = '0;
        ctl_t c = cen();
        Zero = z;
        e.state = st; e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b00; e.ALUControl = 4'b0110;
        e.PCSource = 2'b01; e.pc_en = pcen; e.retire = 1'b1;
        c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b11; c.ALUControl = 4'hF; c.PCSource = 2'b11;
        go(nm, e, c);
    endtask

    task automatic t_jmp(input string nm, input logic [3:0] st, input logic [1:0] pcs, input logic jal);
        ctl_t e = '0;
        ctl_t c = cen();
        e.state = st; e.pc_en = 1'b1; e.PCSource = pcs; e.retire = 1'b1;
        e.RegWrite = jal; e.JAL = jal;
        c.PCSource = 2'b11;
        go(nm, e, c);
    endtask

    task automatic t_halt();
        ctl_t e = '0;
        ctl_t c = cen();
        mem_ready = 1'b1;
        e.state = 4'hF; e.bus_err = 1'b1;
        go("halt", e, c);
    endtask

    logic [5:0] rt_fn [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100111, 6'b101010, 6'b000000, 6'b000010};
    logic [3:0] rt_alu[8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                              4'b1100, 4'b0111, 4'b1000, 4'b1001};

    initial begin
        reset = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
        Opcode = 6'b100011; Funct = 6'b000000;
        @(posedge clk);
        #1;
        t_reset(1'b1);
        t_reset(1'b1);

        // lw with memory always ready: 5 cycles
        set_instr(6'b100011, 6'b000000);
        t_fetch(1'b1); t_decode(1'b0); t_exec_imm("memadr", 4'd2, 4'b0010);
        t_mem(1'b0, 1'b1); t_wb("memwb", 4'd4, 1'b0, 1'b1);

        // sw behind a 3-cycle fetch stall, one-cycle write stall
        set_instr(6'b101011, 6'b000000);
        repeat (3) t_fetch(1'b0);
        t_fetch(1'b1); t_decode(1'b0); t_exec_imm("memadr", 4'd2, 4'b0010);
        t_mem(1'b1, 1'b0); t_mem(1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            set_instr(6'b000000, rt_fn[i]);
            t_fetch(1'b1); t_decode(1'b0); t_rtype(rt_alu[i], 1'b0);
            t_wb("aluwb", 4'd7, 1'b1, 1'b0);
        end

        set_instr(6'b001000, 6'b000000);
        t_fetch(1'b1); t_decode(1'b0); t_exec_imm("addi", 4'd8, 4'b0010);
        t_wb("iwb", 4'd10, 1'b0, 1'b0);
        set_instr(6'b001010, 6'b000000);
        t_fetch(1'b1); t_decode(1'b0); t_exec_imm("slti", 4'd9, 4'b0111);
        t_wb("iwb", 4'd10, 1'b0, 1'b0);

        set_instr(6'b000100, 6'b000000);
        t_fetch(1'b1); t_decode(1'b0); t_br("beq_taken", 4'd11, 1'b1, 1'b1);
        t_fetch(1'b1); t_decode(1'b0); t_br("beq_not", 4'd11, 1'b0, 1'b0);
        set_instr(6'b000101, 6'b000000);
        t_fetch(1'b1); t_decode(1'b0); t_br("bne_taken", 4'd12, 1'b0, 1'b1);
        t_fetch(1'b1); t_decode(1'b0); t_br("bne_not", 4'd12, 1'b1, 1'b0);

        set_instr(6'b000010, 6'b000000);
        t_fetch(1'b1); t_decode(1'b0); t_jmp("jump", 4'd13, 2'b10, 1'b0);
        set_instr(6'b000011, 6'b000000);
        t_fetch(1'b1); t_decode(1'b0); t_jmp("jal", 4'd14, 2'b10, 1'b1);
        set_instr(6'b000000, 6'b001000);
        t_fetch(1'b1); t_decode(1'b0); t_jmp("jr", 4'd15, 2'b11, 1'b0);

        // Unsupported opcode, then unsupported funct; each returns straight to FETCH
        set_instr(6'b111111, 6'b000000);
        t_fetch(1'b1); t_decode(1'b1);
        set_instr(6'b000010, 6'b000000);
        t_fetch(1'b1); t_decode(1'b0); t_jmp("jump", 4'd13, 2'b10, 1'b0);
        set_instr(6'b000000, 6'b111111);
        t_fetch(1'b1); t_decode(1'b0); t_rtype(4'b0000, 1'b1);
        set_instr(6'b000010, 6'b000000);
        t_fetch(1'b1);

        // Ready arriving in the limit cycle still completes the load
        set_instr(6'b100011, 6'b000000);
        t_decode(1'b0); t_exec_imm("memadr", 4'd2, 4'b0010);
        repeat (4) t_mem(1'b0, 1'b0);
        t_mem(1'b0, 1'b1); t_wb("memwb", 4'd4, 1'b0, 1'b1);

        // One more low cycle times out into HALT, which only reset leaves
        t_fetch(1'b1); t_decode(1'b0); t_exec_imm("memadr", 4'd2, 4'b0010);
        repeat (5) t_mem(1'b0, 1'b0);
        repeat (3) t_halt();
        t_reset(1'b0);
        t_reset(1'b1);

        // Reset in the middle of a store suppresses the write
        set_instr(6'b101011, 6'b000000);
        t_fetch(1'b1); t_decode(1'b0); t_exec_imm("memadr", 4'd2, 4'b0010);
        t_mem(1'b1, 1'b0);
        t_reset(1'b0);
        t_fetch(1'b1);

        for (int k = 0; k < 5 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
